// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to variable-latency imem, feeds IF/ID.
// state | meaning
// FETCH | request outstanding at pc, present data on imem_ready
// HOLD  | IF/ID stalled, buffered instruction re-presented, no request
// HALT  | HLT consumed, no fetch until redirect or reset
module if_fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_in,
  input  logic        redirect,
  input  logic [15:0] redirect_addr,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [15:0] instr_out,
  output logic [15:0] pc_incr_out,
  output logic        instr_valid,
  output logic        flush_if_out
);

  localparam logic [15:0] NOP = 16'hA000;
  localparam logic [3:0]  HLT_OP = 4'hF;

  typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, HALT = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] hold_buf_q, hold_buf_d;
  logic        redir_pend_q, redir_pend_d;
  logic [15:0] redir_tgt_q, redir_tgt_d;

  logic        present;
  logic [15:0] present_instr;
  logic [15:0] pc_incr;

  assign pc_incr      = pc_q + 16'd1;
  assign pc_incr_out  = pc_incr;
  assign imem_addr    = pc_q;
  assign flush_if_out = redirect;

  always_comb begin
    present       = 1'b0;
    present_instr = NOP;
    if (!redirect) begin
      if (state_q == FETCH && imem_ready && !redir_pend_q) begin
        present       = 1'b1;
        present_instr = imem_rdata;
      end else if (state_q == HOLD) begin
        present       = 1'b1;
        present_instr = hold_buf_q;
      end
    end
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_out   = NOP;
    instr_valid = 1'b0;
    if (rst_n) begin
      imem_req    = (state_q == FETCH);
      instr_out   = present_instr;
      instr_valid = present;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_buf_d   = hold_buf_q;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          if (imem_ready) begin
            pc_d         = redirect_addr;
            redir_pend_d = 1'b0;
          end else begin
            // access still in flight: retarget once it completes
            redir_pend_d = 1'b1;
            redir_tgt_d  = redirect_addr;
          end
        end else if (imem_ready) begin
          if (redir_pend_q) begin
            pc_d         = redir_tgt_q;
            redir_pend_d = 1'b0;
          end else if (stall_in) begin
            hold_buf_d = imem_rdata;
            state_d    = HOLD;
          end else begin
            pc_d = pc_incr;
            if (imem_rdata[15:12] == HLT_OP) state_d = HALT;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d       = redirect_addr;
          hold_buf_d = NOP;
          state_d    = FETCH;
        end else if (!stall_in) begin
          pc_d    = pc_incr;
          state_d = (hold_buf_q[15:12] == HLT_OP) ? HALT : FETCH;
        end
      end
      HALT: begin
        if (redirect) begin
          pc_d    = redirect_addr;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= 16'h0000;
      hold_buf_q   <= NOP;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_buf_q   <= hold_buf_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; memory handshake is driven by hand each cycle.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall_in;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic [15:0] instr_out;
  logic [15:0] pc_incr_out;
  logic        instr_valid;
  logic        flush_if_out;

  int tests_run = 0;
  int tests_failed = 0;

  if_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .redirect(redirect),
    .redirect_addr(redirect_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .instr_out(instr_out),
    .pc_incr_out(pc_incr_out), .instr_valid(instr_valid), .flush_if_out(flush_if_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // inputs for the coming cycle, then let combinational outputs settle
  task automatic drive(input logic st, input logic rd, input logic [15:0] ra,
                       input logic rdy, input logic [15:0] rdat);
    stall_in = st; redirect = rd; redirect_addr = ra; imem_ready = rdy; imem_rdata = rdat;
    #2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic req, input logic [15:0] addr,
                         input logic vld, input logic [15:0] ins);
    chk({tag, "_req"}, {15'd0, imem_req}, {15'd0, req});
    chk({tag, "_addr"}, imem_addr, addr);
    chk({tag, "_valid"}, {15'd0, instr_valid}, {15'd0, vld});
    chk({tag, "_instr"}, instr_out, ins);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h1234);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h1234);
    chk_out("rst", 1'b0, 16'h0000, 1'b0, 16'hA000);
    chk("rst_pcinc", pc_incr_out, 16'h0001);
    next_cycle();

    // zero-wait stream
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h1111);
    chk_out("zw0", 1'b1, 16'h0000, 1'b1, 16'h1111);
    chk("zw0_pcinc", pc_incr_out, 16'h0001);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h2222);
    chk_out("zw1", 1'b1, 16'h0001, 1'b1, 16'h2222);
    chk("zw1_pcinc", pc_incr_out, 16'h0002);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h3333);
    chk_out("zw2", 1'b1, 16'h0002, 1'b1, 16'h3333);
    chk("zw2_pcinc", pc_incr_out, 16'h0003);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h4444);
    chk_out("zw3", 1'b1, 16'h0003, 1'b1, 16'h4444);
    chk("zw3_pcinc", pc_incr_out, 16'h0004);
    next_cycle();

    // 3-cycle access at 0x0004; stall during wait must be ignored
    drive(1'b0, 1'b0, 16'h0, 1'b0, 16'hDEAD);
    chk_out("lat0", 1'b1, 16'h0004, 1'b0, 16'hA000);
    next_cycle();
    drive(1'b1, 1'b0, 16'h0, 1'b0, 16'hDEAD);
    chk_out("lat1", 1'b1, 16'h0004, 1'b0, 16'hA000);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h5555);
    chk_out("lat2", 1'b1, 16'h0004, 1'b1, 16'h5555);
    next_cycle();

    // stall two cycles when 0x2222 returns at 0x0005
    drive(1'b1, 1'b0, 16'h0, 1'b1, 16'h2222);
    chk_out("stl0", 1'b1, 16'h0005, 1'b1, 16'h2222);
    next_cycle();
    drive(1'b1, 1'b0, 16'h0, 1'b1, 16'h9999);
    chk_out("stl1", 1'b0, 16'h0005, 1'b1, 16'h2222);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h9999);
    chk_out("stl2", 1'b0, 16'h0005, 1'b1, 16'h2222);
    next_cycle();

    // redirect during outstanding access at 0x0006; latest target wins
    drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk_out("rdo0", 1'b1, 16'h0006, 1'b0, 16'hA000);
    next_cycle();
    drive(1'b0, 1'b1, 16'h0030, 1'b0, 16'h0);
    chk("rdo1_flush", {15'd0, flush_if_out}, 16'h0001);
    next_cycle();
    drive(1'b0, 1'b1, 16'h0040, 1'b0, 16'h0);
    chk_out("rdo2", 1'b1, 16'h0006, 1'b0, 16'hA000);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h7777);
    chk_out("rdo3", 1'b1, 16'h0006, 1'b0, 16'hA000);
    chk("rdo3_flush", {15'd0, flush_if_out}, 16'h0000);
    next_cycle();

    // HLT at 0x0040, then redirect to 0xFFFF
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'hF000);
    chk_out("hlt0", 1'b1, 16'h0040, 1'b1, 16'hF000);
    chk("hlt0_pcinc", pc_incr_out, 16'h0041);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h9999);
    chk_out("hlt1", 1'b0, 16'h0041, 1'b0, 16'hA000);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h9999);
    chk_out("hlt2", 1'b0, 16'h0041, 1'b0, 16'hA000);
    next_cycle();
    drive(1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0);
    chk_out("hlt3", 1'b0, 16'h0041, 1'b0, 16'hA000);
    chk("hlt3_flush", {15'd0, flush_if_out}, 16'h0001);
    next_cycle();

    // wrap at 0xFFFF
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h1357);
    chk_out("wrap0", 1'b1, 16'hFFFF, 1'b1, 16'h1357);
    chk("wrap0_pcinc", pc_incr_out, 16'h0000);
    next_cycle();

    // redirect while in HOLD
    drive(1'b1, 1'b0, 16'h0, 1'b1, 16'h2468);
    chk_out("hrd0", 1'b1, 16'h0000, 1'b1, 16'h2468);
    next_cycle();
    drive(1'b1, 1'b1, 16'h0100, 1'b0, 16'h0);
    chk_out("hrd1", 1'b0, 16'h0000, 1'b0, 16'hA000);
    next_cycle();

    // redirect in FETCH with data ready: data dropped, no pending retarget
    drive(1'b0, 1'b1, 16'h0200, 1'b1, 16'hABCD);
    chk_out("frd0", 1'b1, 16'h0100, 1'b0, 16'hA000);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h1111);
    chk_out("frd1", 1'b1, 16'h0200, 1'b1, 16'h1111);
    next_cycle();

    // HLT consumed from HOLD
    drive(1'b1, 1'b0, 16'h0, 1'b1, 16'hF123);
    chk_out("hh0", 1'b1, 16'h0201, 1'b1, 16'hF123);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk_out("hh1", 1'b0, 16'h0201, 1'b1, 16'hF123);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h5678);
    chk_out("hh2", 1'b0, 16'h0202, 1'b0, 16'hA000);
    next_cycle();
    drive(1'b0, 1'b1, 16'h0300, 1'b0, 16'h0);
    next_cycle();

    // reset mid-access
    drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk_out("mrs0", 1'b1, 16'h0300, 1'b0, 16'hA000);
    next_cycle();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'h4321);
    chk_out("mrs1", 1'b0, 16'h0300, 1'b0, 16'hA000);
    next_cycle();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk_out("mrs2", 1'b1, 16'h0000, 1'b0, 16'hA000);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
